// File: rtl/stage_execute_pkg.sv
// Shared constants for the execute stage: opcodes, ALU ops, overflow status
// codes, the status destination register and the multiply/divide FSM states.
package stage_execute_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [31:0] ST_ADD  = 32'd1;
    localparam logic [31:0] ST_ADDI = 32'd2;
    localparam logic [31:0] ST_SUB  = 32'd3;
    localparam logic [31:0] ST_MUL  = 32'd4;
    localparam logic [31:0] ST_DIV  = 32'd5;

    localparam logic [4:0] REG_STATUS = 5'd30;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic [31:0] sext_imm(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction

endpackage

// File: rtl/stage_execute_multdiv.sv
// Iterative signed multiply (shift-add) and signed restoring divide.
// One start pulse (ctrl_mult_i / ctrl_div_i) launches MD_ITER iteration
// cycles; ready_o is high for the single DONE cycle holding the result.
module stage_execute_multdiv
    import stage_execute_pkg::*;
#(
    parameter int MD_ITER = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        ctrl_mult_i,
    input  logic        ctrl_div_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic        ovf_o,
    output logic [31:0] result_o
);

    localparam int CNT_W = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_ITER - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             ready_q;

    logic [63:0] acc_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        neg_q;
    logic        dz_q;
    logic [31:0] result_q;
    logic        ovf_q;

    logic        last;
    logic [63:0] addend;
    logic [63:0] acc_d;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    assign busy_o   = busy_q;
    assign ready_o  = ready_q;
    assign ovf_o    = ovf_q;
    assign result_o = result_q;

    // Next iteration values: the multiplier bit of weight -2^31 subtracts,
    // the others add; divide works on magnitudes, one quotient bit per cycle.
    always_comb begin
        last    = (cnt_q == LAST);
        addend  = mplier_q[0] ? mcand_q : 64'd0;
        acc_d   = last ? (acc_q - addend) : (acc_q + addend);
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvs_q};
        if (trial[32]) begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end else begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end
    end

    // Control FSM: IDLE -> MUL/DIV for MD_ITER cycles -> DONE -> IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else if (flush_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                    if (ctrl_mult_i) begin
                        state_q <= MD_MUL;
                        busy_q  <= 1'b1;
                    end else if (ctrl_div_i) begin
                        state_q <= MD_DIV;
                        busy_q  <= 1'b1;
                    end
                end
                MD_MUL, MD_DIV: begin
                    if (last) begin
                        state_q <= MD_DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Operand/partial-result datapath; loads operands while idle so they are
    // captured on the start edge, and latches the final result on the last
    // iteration.
    always_ff @(posedge clk_i) begin
        case (state_q)
            MD_IDLE: begin
                mcand_q  <= {{32{a_i[31]}}, a_i};
                mplier_q <= b_i;
                acc_q    <= 64'd0;
                rem_q    <= 32'd0;
                quo_q    <= mag(a_i);
                dvs_q    <= mag(b_i);
                neg_q    <= a_i[31] ^ b_i[31];
                dz_q     <= (b_i == 32'd0);
            end
            MD_MUL: begin
                acc_q    <= acc_d;
                mcand_q  <= {mcand_q[62:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[31:1]};
                if (last) begin
                    result_q <= acc_d[31:0];
                    ovf_q    <= (acc_d[63:32] != {32{acc_d[31]}});
                end
            end
            MD_DIV: begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                if (last) begin
                    result_q <= neg_q ? (~quo_d + 32'd1) : quo_d;
                    ovf_q    <= dz_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/stage_execute.sv
// Execute stage: single-cycle ALU/address generation plus a multicycle
// multiply/divide unit, feeding one registered output bundle to memory.
module stage_execute
    import stage_execute_pkg::*;
#(
    parameter int MD_ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        flush,
    input  logic [4:0]  opcode_in,
    input  logic [4:0]  aluop_in,
    input  logic [4:0]  shamt_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [16:0] imm_in,
    output logic        stall,
    output logic        valid_out,
    output logic [4:0]  opcode_out,
    output logic [4:0]  rd_out,
    output logic [31:0] o_out,
    output logic [31:0] b_out
);

    logic        md_busy;
    logic        md_ready;
    logic        md_ovf;
    logic [31:0] md_result;

    logic        is_alu;
    logic        is_md_op;
    logic        accept;
    logic        start_mul;
    logic        start_div;

    logic [31:0]        opb;
    logic [31:0]        sum;
    logic [31:0]        diff;
    logic signed [31:0] a_s;
    logic               add_ovf;
    logic               sub_ovf;
    logic [31:0]        alu_res;
    logic [4:0]         alu_rd;

    logic [4:0]  md_rd_q;
    logic [4:0]  md_op_q;
    logic [31:0] md_b_q;
    logic        md_div_q;

    logic        valid_d,  valid_q;
    logic [4:0]  op_d,     op_q;
    logic [4:0]  rd_d,     rd_q;
    logic [31:0] o_d,      o_q;
    logic [31:0] b_d,      b_q;

    // While the unit is busy, or in its DONE cycle, the presented instruction
    // is the one already being executed, so nothing new is accepted.
    assign is_alu    = (opcode_in == OP_ALU);
    assign is_md_op  = is_alu && ((aluop_in == ALU_MUL) || (aluop_in == ALU_DIV));
    assign accept    = valid_in & ~flush & ~reset & ~md_busy & ~md_ready;
    assign start_mul = accept & is_alu & (aluop_in == ALU_MUL);
    assign start_div = accept & is_alu & (aluop_in == ALU_DIV);
    assign stall     = ~flush & ~reset & (start_mul | start_div | md_busy);

    stage_execute_multdiv #(
        .MD_ITER (MD_ITER)
    ) u_multdiv (
        .clk_i       (clock),
        .rst_i       (reset),
        .flush_i     (flush),
        .ctrl_mult_i (start_mul),
        .ctrl_div_i  (start_div),
        .a_i         (a_in),
        .b_i         (b_in),
        .busy_o      (md_busy),
        .ready_o     (md_ready),
        .ovf_o       (md_ovf),
        .result_o    (md_result)
    );

    // Single-cycle ALU with overflow substitution for add/addi/sub.
    always_comb begin
        opb     = is_alu ? b_in : sext_imm(imm_in);
        sum     = a_in + opb;
        diff    = a_in - opb;
        a_s     = a_in;
        add_ovf = (a_in[31] == opb[31]) && (sum[31] != a_in[31]);
        sub_ovf = (a_in[31] != opb[31]) && (diff[31] != a_in[31]);
        alu_res = 32'd0;
        alu_rd  = rd_in;
        case (opcode_in)
            OP_ALU: begin
                case (aluop_in)
                    ALU_ADD: begin
                        alu_res = add_ovf ? ST_ADD : sum;
                        alu_rd  = add_ovf ? REG_STATUS : rd_in;
                    end
                    ALU_SUB: begin
                        alu_res = sub_ovf ? ST_SUB : diff;
                        alu_rd  = sub_ovf ? REG_STATUS : rd_in;
                    end
                    ALU_AND: alu_res = a_in & opb;
                    ALU_OR:  alu_res = a_in | opb;
                    ALU_SLL: alu_res = a_in << shamt_in;
                    ALU_SRA: alu_res = a_s >>> shamt_in;
                    default: alu_res = 32'd0;
                endcase
            end
            OP_ADDI: begin
                alu_res = add_ovf ? ST_ADDI : sum;
                alu_rd  = add_ovf ? REG_STATUS : rd_in;
            end
            OP_SW, OP_LW: alu_res = sum;
            default: alu_res = 32'd0;
        endcase
    end

    // Remember the destination, opcode and store data of a multicycle op.
    always_ff @(posedge clock) begin
        if (start_mul | start_div) begin
            md_rd_q  <= rd_in;
            md_op_q  <= opcode_in;
            md_b_q   <= b_in;
            md_div_q <= start_div;
        end
    end

    // Output bundle selection: flush kills, a finished multicycle op wins,
    // otherwise an accepted single-cycle op; idle cycles hold the data.
    always_comb begin
        valid_d = 1'b0;
        op_d    = op_q;
        rd_d    = rd_q;
        o_d     = o_q;
        b_d     = b_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (md_ready) begin
            valid_d = 1'b1;
            op_d    = md_op_q;
            rd_d    = md_ovf ? REG_STATUS : md_rd_q;
            o_d     = md_ovf ? (md_div_q ? ST_DIV : ST_MUL) : md_result;
            b_d     = md_b_q;
        end else if (accept && !is_md_op) begin
            valid_d = 1'b1;
            op_d    = opcode_in;
            rd_d    = alu_rd;
            o_d     = alu_res;
            b_d     = b_in;
        end
    end

    // Output register toward the memory stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= 5'd0;
            rd_q    <= 5'd0;
            o_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            o_q     <= o_d;
            b_q     <= b_d;
        end
    end

    assign valid_out  = valid_q;
    assign opcode_out = op_q;
    assign rd_out     = rd_q;
    assign o_out      = o_q;
    assign b_out      = b_q;

endmodule

// File: tb/tb_stage_execute.sv
// Bench for stage_execute: directed cases plus randomized instructions
// checked against an arithmetic reference model.
module tb_stage_execute;

    localparam int MD_ITER = 32;

    logic        clock;
    logic        reset;
    logic        valid_in;
    logic        flush;
    logic [4:0]  opcode_in;
    logic [4:0]  aluop_in;
    logic [4:0]  shamt_in;
    logic [4:0]  rd_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [16:0] imm_in;
    logic        stall;
    logic        valid_out;
    logic [4:0]  opcode_out;
    logic [4:0]  rd_out;
    logic [31:0] o_out;
    logic [31:0] b_out;

    int checks = 0;
    int errors = 0;

    stage_execute #(.MD_ITER(MD_ITER)) dut (
        .clock      (clock),
        .reset      (reset),
        .valid_in   (valid_in),
        .flush      (flush),
        .opcode_in  (opcode_in),
        .aluop_in   (aluop_in),
        .shamt_in   (shamt_in),
        .rd_in      (rd_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .imm_in     (imm_in),
        .stall      (stall),
        .valid_out  (valid_out),
        .opcode_out (opcode_out),
        .rd_out     (rd_out),
        .o_out      (o_out),
        .b_out      (b_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit fits32(input longint r);
        return (r >= -(64'sd1 <<< 31)) && (r < (64'sd1 <<< 31));
    endfunction

    // Reference behaviour from the instruction semantics, using wide integers.
    function automatic void model(input logic [4:0] op, input logic [4:0] alu,
                                  input logic [4:0] sh, input logic [4:0] rd,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [16:0] imm,
                                  output logic [31:0] eo, output logic [4:0] erd,
                                  output bit md);
        longint sa, sb, si, r;
        int q;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        si  = longint'($signed(imm));
        eo  = 32'd0;
        erd = rd;
        md  = 1'b0;
        case (op)
            5'd0: begin
                case (alu)
                    5'd0: begin r = sa + sb; if (fits32(r)) eo = r[31:0]; else begin eo = 1; erd = 30; end end
                    5'd1: begin r = sa - sb; if (fits32(r)) eo = r[31:0]; else begin eo = 3; erd = 30; end end
                    5'd2: eo = a & b;
                    5'd3: eo = a | b;
                    5'd4: begin r = sa * (64'sd1 <<< sh); eo = r[31:0]; end
                    5'd5: begin r = sa >>> sh; eo = r[31:0]; end
                    5'd6: begin
                        md = 1'b1;
                        r  = sa * sb;
                        if (fits32(r)) eo = r[31:0]; else begin eo = 4; erd = 30; end
                    end
                    5'd7: begin
                        md = 1'b1;
                        if (b == 32'd0) begin eo = 5; erd = 30; end
                        else begin q = int'(sa) / int'(sb); eo = q; end
                    end
                    default: eo = 32'd0;
                endcase
            end
            5'd5: begin r = sa + si; if (fits32(r)) eo = r[31:0]; else begin eo = 2; erd = 30; end end
            5'd7, 5'd8: begin r = sa + si; eo = r[31:0]; end
            default: eo = 32'd0;
        endcase
    endfunction

    task automatic put(input logic v, input logic [4:0] op, input logic [4:0] alu,
                       input logic [4:0] sh, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [16:0] imm);
        valid_in  = v;
        opcode_in = op;
        aluop_in  = alu;
        shamt_in  = sh;
        rd_in     = rd;
        a_in      = a;
        b_in      = b;
        imm_in    = imm;
    endtask

    // Present one instruction, hold it while stalled, and check the result.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [4:0] alu,
                          input logic [4:0] sh, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [16:0] imm);
        logic [31:0] eo;
        logic [4:0]  erd;
        bit          md;
        int          n;
        bit          early;
        model(op, alu, sh, rd, a, b, imm, eo, erd, md);
        @(negedge clock);
        put(1'b1, op, alu, sh, rd, a, b, imm);
        #1;
        chk({tag, "_stall_accept"}, 32'(stall), md ? 32'd1 : 32'd0);
        if (md) begin
            n = 1;
            early = 1'b0;
            while (n < 200) begin
                @(posedge clock);
                #1;
                if (valid_out) early = 1'b1;
                if (!stall) break;
                n++;
            end
            chk({tag, "_stall_len"}, 32'(n), 32'(MD_ITER + 1));
            chk({tag, "_no_valid_busy"}, 32'(early), 32'd0);
            @(negedge clock);
            valid_in = 1'b0;
        end
        if (md) begin
            @(posedge clock);
            #1;
        end else begin
            @(posedge clock);
            #1;
        end
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_o"}, o_out, eo);
        chk({tag, "_rd"}, 32'(rd_out), 32'(erd));
        chk({tag, "_opcode"}, 32'(opcode_out), 32'(op));
        chk({tag, "_b"}, b_out, b);
        @(negedge clock);
        valid_in = 1'b0;
        @(posedge clock);
        #1;
        chk({tag, "_valid_drop"}, 32'(valid_out), 32'd0);
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 4))
            0: return $urandom();
            1: return 32'($signed($urandom_range(0, 200)) - 100);
            2: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            3: return 32'($urandom_range(0, 32'hFFFF));
            default: return 32'($urandom_range(0, 12));
        endcase
    endfunction

    initial begin : stim
        bit           any_valid;
        logic [4:0]   op, alu;
        logic [31:0]  a, b;
        int           kind;

        reset = 1'b1;
        flush = 1'b0;
        put(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 17'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_opcode", 32'(opcode_out), 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        chk("rst_o", o_out, 32'd0);
        chk("rst_b", b_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed examples and boundaries.
        run_op("add_7_5", 5'd0, 5'd0, 5'd0, 5'd3, 32'd7, 32'd5, 17'd0);
        chk("add_7_5_exact", o_out, 32'd12);
        run_op("sw_addr", 5'd7, 5'd0, 5'd0, 5'd9, 32'h100, 32'hDEAD, 17'h1FFFC);
        chk("sw_addr_exact", o_out, 32'hFC);
        run_op("mul_m3_7", 5'd0, 5'd6, 5'd0, 5'd4, 32'hFFFF_FFFD, 32'd7, 17'd0);
        chk("mul_m3_7_exact", o_out, 32'hFFFF_FFEB);
        run_op("add_ovf", 5'd0, 5'd0, 5'd0, 5'd2, 32'h7FFF_FFFF, 32'd1, 17'd0);
        chk("add_ovf_rd30", 32'(rd_out), 32'd30);
        run_op("addi_ovf", 5'd5, 5'd0, 5'd0, 5'd2, 32'h7FFF_FFFF, 32'd0, 17'd1);
        run_op("sub_ovf", 5'd0, 5'd1, 5'd0, 5'd2, 32'h8000_0000, 32'd1, 17'd0);
        run_op("mul_ovf", 5'd0, 5'd6, 5'd0, 5'd2, 32'h0001_0000, 32'h0001_0000, 17'd0);
        run_op("div_by_0", 5'd0, 5'd7, 5'd0, 5'd8, 32'd10, 32'd0, 17'd0);
        chk("div_by_0_code", o_out, 32'd5);
        run_op("div_m7_2", 5'd0, 5'd7, 5'd0, 5'd8, 32'hFFFF_FFF9, 32'd2, 17'd0);
        chk("div_m7_2_exact", o_out, 32'hFFFF_FFFD);
        run_op("lw_wrap", 5'd8, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 32'd0, 17'd1);
        run_op("sra", 5'd0, 5'd5, 5'd4, 5'd5, 32'h8000_0010, 32'd0, 17'd0);
        run_op("sll", 5'd0, 5'd4, 5'd3, 5'd5, 32'h1234_5678, 32'd0, 17'd0);
        run_op("unk_op", 5'd31, 5'd0, 5'd0, 5'd6, 32'd77, 32'd88, 17'd5);
        run_op("unk_aluop", 5'd0, 5'd10, 5'd0, 5'd6, 32'd77, 32'd88, 17'd5);

        // flush at iteration 10 of a divide, then an add right after.
        @(negedge clock);
        put(1'b1, 5'd0, 5'd7, 5'd0, 5'd4, 32'd100, 32'd7, 17'd0);
        @(posedge clock);
        repeat (10) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        #1;
        chk("flush_stall_low", 32'(stall), 32'd0);
        @(posedge clock);
        #1;
        chk("flush_valid", 32'(valid_out), 32'd0);
        @(negedge clock);
        flush = 1'b0;
        put(1'b1, 5'd0, 5'd0, 5'd0, 5'd6, 32'd3, 32'd4, 17'd0);
        #1;
        chk("post_flush_stall", 32'(stall), 32'd0);
        @(posedge clock);
        #1;
        chk("post_flush_valid", 32'(valid_out), 32'd1);
        chk("post_flush_o", o_out, 32'd7);
        chk("post_flush_rd", 32'(rd_out), 32'd6);
        @(negedge clock);
        valid_in = 1'b0;
        any_valid = 1'b0;
        repeat (MD_ITER + 5) begin
            @(posedge clock);
            #1;
            if (valid_out) any_valid = 1'b1;
        end
        chk("flush_no_late_pulse", 32'(any_valid), 32'd0);

        // flush together with a presented instruction discards it.
        @(negedge clock);
        put(1'b1, 5'd0, 5'd0, 5'd0, 5'd6, 32'd1, 32'd1, 17'd0);
        flush = 1'b1;
        @(posedge clock);
        #1;
        chk("flush_with_valid", 32'(valid_out), 32'd0);
        chk("flush_with_valid_o", o_out, 32'd7);
        @(negedge clock);
        flush = 1'b0;
        valid_in = 1'b0;

        // Asynchronous reset in the middle of a multiply.
        @(negedge clock);
        put(1'b1, 5'd0, 5'd6, 5'd0, 5'd4, 32'd5, 32'd9, 17'd0);
        repeat (6) @(posedge clock);
        #2;
        reset = 1'b1;
        valid_in = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_o", o_out, 32'd0);
        chk("mid_rst_rd", 32'(rd_out), 32'd0);
        chk("mid_rst_opcode", 32'(opcode_out), 32'd0);
        chk("mid_rst_b", b_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        any_valid = 1'b0;
        repeat (MD_ITER + 5) begin
            @(posedge clock);
            #1;
            if (valid_out) any_valid = 1'b1;
        end
        chk("mid_rst_no_pulse", 32'(any_valid), 32'd0);

        // Randomized instructions against the reference model.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 13);
            a = rv();
            b = rv();
            alu = 5'd0;
            if (kind <= 7) begin
                op  = 5'd0;
                alu = 5'(kind);
            end else if (kind == 8) op = 5'd5;
            else if (kind == 9) op = 5'd7;
            else if (kind == 10) op = 5'd8;
            else if (kind == 11) begin
                op  = 5'd0;
                alu = 5'($urandom_range(8, 31));
            end else if (kind == 12) op = 5'($urandom_range(9, 31));
            else op = 5'd0;
            if (op == 5'd0 && alu == 5'd7 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            run_op("rand", op, alu, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 29)),
                   a, b, 17'($urandom()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
